// File: rtl/clkrst_monitor_if.sv
// Signal bundle between the clock/reset generator side and clkrst_monitor.
// The master drives the monitored reset and halt; the slave is the monitor.
interface clkrst_monitor_if #(
  parameter int CNT_W = 32
);
  logic             mon_reset_n;
  logic             halt;
  logic             core_reset_n;
  logic             run_active;
  logic [CNT_W-1:0] rst_len;
  logic             rst_short_err;
  logic             timeout;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output mon_reset_n, halt,
    input  core_reset_n, run_active, rst_len, rst_short_err, timeout, halted, cycle_count
  );

  modport slave (
    input  mon_reset_n, halt,
    output core_reset_n, run_active, rst_len, rst_short_err, timeout, halted, cycle_count
  );
endinterface

// File: rtl/clkrst_monitor.sv
// Synchronizes and measures the generator's active-low reset, stretches its
// release to the core and supervises the run window (halt or cycle timeout).
module clkrst_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_RST_CYCLES = 50,
  parameter int STRETCH_CYCLES = 16,
  parameter int RUN_CYCLES     = 5000000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  clkrst_monitor_if.slave  mon
);

  localparam int SCNT_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  MIN_W     = CNT_W'(MIN_RST_CYCLES);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_FULL  = CNT_W'(RUN_CYCLES);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STRETCH_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_STRETCH,
    ST_RUN,
    ST_HALTED,
    ST_TIMEOUT
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p;
  logic [SYNC_STAGES-1:0] sync_vld_p;
  logic                   s_rst_n;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic               core_q, core_d;
  logic               run_q, run_d;
  logic [CNT_W-1:0]   rst_len_q, rst_len_d;
  logic               short_q, short_d;
  logic               timeout_q, timeout_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cc_q, cc_d;

  // ---- synchronizer stages ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p     <= '0;
      sync_vld_p <= '0;
    end else begin
      sync_p     <= {sync_p[SYNC_STAGES-2:0], mon.mon_reset_n};
      sync_vld_p <= {sync_vld_p[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Zeros left in the chain by reset are not a real low pulse; a valid token
  // travels with the data so the first genuine sample is measured exactly.
  assign s_rst_n = sync_p[SYNC_STAGES-1] | ~sync_vld_p[SYNC_STAGES-1];

  // ---- supervisor state and counters ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ASSERT;
      wcnt_q    <= '0;
      scnt_q    <= '0;
      core_q    <= 1'b0;
      run_q     <= 1'b0;
      rst_len_q <= '0;
      short_q   <= 1'b0;
      timeout_q <= 1'b0;
      halted_q  <= 1'b0;
      cc_q      <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      scnt_q    <= scnt_d;
      core_q    <= core_d;
      run_q     <= run_d;
      rst_len_q <= rst_len_d;
      short_q   <= short_d;
      timeout_q <= timeout_d;
      halted_q  <= halted_d;
      cc_q      <= cc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    scnt_d    = scnt_q;
    core_d    = core_q;
    run_d     = run_q;
    rst_len_d = rst_len_q;
    short_d   = short_q;
    timeout_d = timeout_q;
    halted_d  = halted_q;
    cc_d      = cc_q;

    if (!s_rst_n && state_q != ST_ASSERT) begin
      // The re-assertion cycle is itself the first low cycle of the new pulse.
      state_d = ST_ASSERT;
      wcnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
      core_d  = 1'b0;
      run_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (!s_rst_n) begin
            wcnt_d = sat_inc(wcnt_q);
          end else if (wcnt_q != '0) begin
            rst_len_d = wcnt_q;
            wcnt_d    = '0;
            if (wcnt_q < MIN_W) begin
              short_d = 1'b1;
            end else begin
              state_d = ST_STRETCH;
              scnt_d  = '0;
            end
          end
        end
        ST_STRETCH: begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == SCNT_LAST) begin
            state_d = ST_RUN;
            core_d  = 1'b1;
            run_d   = 1'b1;
            cc_d    = '0;
          end
        end
        ST_RUN: begin
          if (mon.halt) begin
            halted_d = 1'b1;
            run_d    = 1'b0;
            state_d  = ST_HALTED;
          end else if (cc_q == RUN_LAST) begin
            cc_d      = RUN_FULL;
            timeout_d = 1'b1;
            run_d     = 1'b0;
            state_d   = ST_TIMEOUT;
          end else begin
            cc_d = cc_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mon.core_reset_n  = core_q;
  assign mon.run_active    = run_q;
  assign mon.rst_len       = rst_len_q;
  assign mon.rst_short_err = short_q;
  assign mon.timeout       = timeout_q;
  assign mon.halted        = halted_q;
  assign mon.cycle_count   = cc_q;

endmodule

// File: doc/clkrst_monitor.md
Name: clkrst_monitor

Overview:
Consumer-side monitor for the bench clock/reset source. It synchronizes the incoming active-low reset and measures its asserted width in clock cycles, rejecting pulses that are too short. It stretches the reset release to the core and supervises the run window after reset, flagging either a halt or a run-cycle timeout. It sits between the clock/reset generator and the PDP8 core/unit under test.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on mon_reset_n (minimum 2)
MIN_RST_CYCLES, 50, minimum legal synchronized reset-low width in clk cycles
STRETCH_CYCLES, 16, cycles core_reset_n is held low after an accepted reset release
RUN_CYCLES, 5000000, cycle budget in RUN before timeout
CNT_W, 32, width of the rst_len and cycle_count counters

Ports:
clk  input  1  single system clock
reset  input  1  asynchronous, active-high reset
mon_reset_n  input  1  monitored active-low reset from the generator; asynchronous to clk
halt  input  1  core halt indication, sampled in RUN only
core_reset_n  output  1  stretched, synchronized active-low reset to the core
run_active  output  1  high only in RUN
rst_len  output  CNT_W  width of the last completed reset-low pulse, in cycles
rst_short_err  output  1  sticky: a reset pulse shorter than MIN_RST_CYCLES was seen
timeout  output  1  sticky: RUN_CYCLES elapsed without halt
halted  output  1  sticky: halt was seen in RUN
cycle_count  output  CNT_W  cycles spent in the current or last RUN

Behaviour:
- Reset (asynchronous, active-high):
  - state=ASSERT; synchronizer flops=0; internal counters=0.
  - Outputs: core_reset_n=0, run_active=0, rst_len=0, rst_short_err=0, timeout=0, halted=0, cycle_count=0.
- Synchronizer: mon_reset_n passes through SYNC_STAGES flops; s_rst_n is the last stage. Both edges incur equal latency, so measured widths are exact in cycles.
- All outputs are registered.
- States:
  - ASSERT: width counter wcnt increments each cycle s_rst_n=0, saturating at 2^CNT_W-1.
    - On the first cycle with s_rst_n=1: rst_len<=wcnt; wcnt<=0.
    - If wcnt<MIN_RST_CYCLES: rst_short_err<=1 and stay in ASSERT (pulse rejected, core stays in reset).
    - Otherwise go to STRETCH with scnt<=0.
    - s_rst_n=1 with wcnt=0 (e.g. after reset) is not a pulse: stay, no update.
  - STRETCH: core_reset_n=0; scnt increments. When scnt==STRETCH_CYCLES-1, go to RUN, set core_reset_n<=1 and cycle_count<=0.
  - RUN: run_active=1; cycle_count increments each cycle.
    - halt=1: halted<=1, go to HALTED; cycle_count not incremented that cycle.
    - Else if cycle_count==RUN_CYCLES-1: cycle_count<=RUN_CYCLES, timeout<=1, go to TIMEOUT.
  - HALTED / TIMEOUT: terminal; core_reset_n stays 1, run_active=0, cycle_count frozen.
- Re-assertion: s_rst_n=0 in any state except ASSERT:
  - go to ASSERT with wcnt<=1, core_reset_n<=0, run_active<=0.
  - cycle_count is held until the next RUN entry clears it.
  - Sticky flags persist; only reset clears them.
- Priority within a cycle: s_rst_n low > halt > timeout. Simultaneous halt and final timeout cycle gives halted=1, timeout=0.
- Latency: core_reset_n rises exactly SYNC_STAGES+STRETCH_CYCLES+1 clk edges after the first edge sampling mon_reset_n=1. It falls within SYNC_STAGES+1 edges of sampled mon_reset_n=0.
- reset asserted mid-RUN: immediate return to reset values, including sticky flags.

Test Plan:
Common settings: SYNC_STAGES=2, MIN_RST_CYCLES=8, STRETCH_CYCLES=4, RUN_CYCLES=20.
1. Hold reset=1 with random mon_reset_n/halt -> all outputs 0, state ASSERT; release reset with mon_reset_n=1 -> no rst_len update, core_reset_n stays 0.
2. mon_reset_n low 10 cycles then high -> rst_len=10, rst_short_err=0, core_reset_n=1 exactly 7 edges after rise sampled, run_active=1.
3. mon_reset_n low 5 cycles then high -> rst_len=5, rst_short_err=1, core_reset_n stays 0; then a 12-cycle pulse -> accepted, rst_len=12, rst_short_err still 1.
4. Accepted reset, no halt -> timeout=1 with cycle_count=20 after 20 RUN cycles, run_active=0, halted=0.
5. Accepted reset, halt pulsed when cycle_count=7 -> halted=1, cycle_count frozen at 7; halt coincident with the final timeout cycle -> halted=1, timeout=0.
6. mon_reset_n driven low at cycle_count=11 -> core_reset_n=0 within 3 edges, cycle_count holds 11; next accepted release -> cycle_count clears to 0 on RUN entry.
